systolic_input_feeder: RTL

SYSTOLIC_INPUT_FEEDER -- requirements
Module: systolic_input_feeder

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_input_feeder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front end: feeder FSM states,
// default array geometry and a helper that sizes the flush counter.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        FINISH = 2'd3
    } feeder_state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_SA_LENGTH  = 256;
    localparam int DEFAULT_CNT_WIDTH  = 16;

    // A one-row array has no flush phase, but the counter still needs one bit.
    function automatic int flush_cnt_width(input int sa_length);
        return (sa_length > 1) ? $clog2(sa_length) : 1;
    endfunction

endpackage

// File: rtl/systolic_input_feeder.sv
// Systolic input feeder: pulls NUM_VECS vectors from the upstream buffer,
// registers each into the skew stage, then pushes SA_LENGTH-1 zero vectors
// so the skew stage drains completely before DONE is raised.
module systolic_input_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SA_LENGTH  = DEFAULT_SA_LENGTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  ASYNC_RST,
    input  logic                  SYNC_RST,
    input  logic                  START,
    input  logic [CNT_WIDTH-1:0]  NUM_VECS,
    input  logic                  IN_VALID,
    input  logic [DATA_WIDTH-1:0] IN_DATA [0:SA_LENGTH-1],
    output logic                  IN_READY,
    output logic                  OUT_EN,
    output logic [DATA_WIDTH-1:0] OUT_DATA [0:SA_LENGTH-1],
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int                FLUSH_W    = flush_cnt_width(SA_LENGTH);
    // The flush counter runs 0..SA_LENGTH-1: the first SA_LENGTH-1 FLUSH
    // cycles register zero vectors, the last one lets the final zero be
    // consumed by the skew stage before FINISH raises DONE.
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(SA_LENGTH - 1);
    localparam bit                SINGLE_ROW = (SA_LENGTH == 1);

    feeder_state_t        state_q;
    feeder_state_t        state_d;
    logic [CNT_WIDTH-1:0] num_vecs_q;
    logic [CNT_WIDTH-1:0] vec_cnt_q;
    logic [FLUSH_W-1:0]   flush_cnt_q;
    logic                 xfer;
    logic                 last_xfer;
    logic                 flush_done;
    logic                 out_load;
    logic                 out_clear;

    // Handshake, tile-boundary detection and output-register controls.
    always_comb begin
        xfer       = (state_q == STREAM) && IN_VALID;
        last_xfer  = xfer && ((vec_cnt_q + CNT_WIDTH'(1)) == num_vecs_q);
        flush_done = (state_q == FLUSH) && (flush_cnt_q == FLUSH_LAST);
        out_load   = xfer;
        out_clear  = (state_q == FLUSH) && !flush_done;
    end

    // Next-state logic for the tile sequencer.
    always_comb begin
        // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = (NUM_VECS == '0) ? FINISH : STREAM;
                end
            end
            STREAM: begin
                if (last_xfer) begin
                    state_d = SINGLE_ROW ? FINISH : FLUSH;
                end
            end
            FLUSH: begin
                if (flush_done) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; the synchronous reset overrides START and IN_VALID.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!ASYNC_RST) begin
            state_q <= IDLE;
        end else if (SYNC_RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Tile length latch, vector counter and flush counter.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            num_vecs_q  <= '0;
            vec_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else if (SYNC_RST) begin
            num_vecs_q  <= '0;
            vec_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_q == IDLE) && START) begin
                num_vecs_q <= NUM_VECS;
                vec_cnt_q  <= '0;
            end else if (xfer) begin
                vec_cnt_q <= vec_cnt_q + CNT_WIDTH'(1);
            end

            if ((state_q == FLUSH) && !flush_done) begin
                flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
            end else begin
                flush_cnt_q <= '0;
            end
        end
    end

    // Advance enable for the skew stage: one cycle after a transfer or a flush slot.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            OUT_EN <= 1'b0;
        end else if (SYNC_RST) begin
            OUT_EN <= 1'b0;
        end else begin
            OUT_EN <= out_load || out_clear;
        end
    end

    // One output register per array row: load on transfer, zero during flush, hold otherwise.
    for (genvar i = 0; i < SA_LENGTH; i++) begin : g_out
        logic [DATA_WIDTH-1:0] data_q;

        // Row i element register feeding skew stage input i.
        always_ff @(posedge CLK or negedge ASYNC_RST) begin
            // NOTE: this register array is reset because a stale value would leak into the array after reset.
            if (!ASYNC_RST) begin
                data_q <= '0;
            end else if (SYNC_RST) begin
                data_q <= '0;
            end else if (out_load) begin
                data_q <= IN_DATA[i];
            end else if (out_clear) begin
                data_q <= '0;
            end
        end

        assign OUT_DATA[i] = data_q;
    end

    assign IN_READY = (state_q == STREAM);
    assign BUSY     = (state_q != IDLE);
    assign DONE     = (state_q == FINISH);

endmodule
